// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter.
// State codes, owner tags and the default request bundle.
package cpu_mem_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int STARVE_LIMIT_DEF = 4;

    typedef struct packed {
        logic                  wr;
        logic [1:0]            size;
        logic [3:0]            wstrb;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } req_t;

endpackage

// File: rtl/cpu_mem_arbiter.sv
// Fetch / load-store arbiter onto one SRAM-like bus port.
// Data has priority; fetch wins after STARVE_LIMIT consecutive data grants.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef struct packed {
        logic              wr;
        logic [1:0]        size;
        logic [3:0]        wstrb;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cap_t;

    localparam int CW = $clog2(STARVE_LIMIT + 2);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [1:0]    state;
    owner_e        owner;
    logic [CW-1:0] starve_cnt;
    cap_t          cap;

    logic idle;
    logic starved;
    logic grant_d;
    logic grant_i;
    logic wait_done;

    assign idle    = resetn && (state == S_IDLE);
    assign starved = (starve_cnt == LIMIT) && inst_req;
    assign grant_d = idle && data_req && !starved;
    assign grant_i = idle && inst_req && !grant_d;

    assign inst_addr_ok = grant_i;
    assign data_addr_ok = grant_d;

    // Only the owner of the outstanding transaction sees the response.
    assign wait_done    = resetn && (state == S_WAIT) && bus_data_ok;
    assign inst_data_ok = wait_done && (owner == OWN_INST);
    assign data_data_ok = wait_done && (owner == OWN_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    assign bus_req   = (state == S_REQ);
    assign bus_wr    = cap.wr;
    assign bus_size  = cap.size;
    assign bus_wstrb = cap.wstrb;
    assign bus_addr  = cap.addr;
    assign bus_wdata = cap.wdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            owner      <= OWN_INST;
            starve_cnt <= '0;
            cap        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_d) begin
                        state <= S_REQ;
                        owner <= OWN_DATA;
                        cap   <= '{data_wr, data_size, data_wstrb,
                                   data_addr, data_wdata};
                        if (!inst_req)
                            starve_cnt <= '0;
                        else if (starve_cnt != LIMIT)
                            starve_cnt <= starve_cnt + 1'b1;
                    end else if (grant_i) begin
                        state      <= S_REQ;
                        owner      <= OWN_INST;
                        cap        <= '{inst_wr, inst_size, inst_wstrb,
                                        inst_addr, inst_wdata};
                        starve_cnt <= '0;
                    end
                end
                S_REQ: begin
                    if (bus_addr_ok)
                        state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus_data_ok)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_mem_arbiter.md
# cpu_mem_arbiter

Shares one SRAM-like memory port between the CPU's instruction-fetch requester and its load/store requester. It sits between the pipeline's inst/data memory interfaces and the single downstream bus bridge. It sequences one transaction at a time through request, address-accept and data-return phases. Data requests have priority, with a starvation guard for fetch.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, consecutive data grants, while fetch waits, after which fetch must win

- `clk` in 1: single clock, rising edge
- `resetn` in 1: reset, asynchronous, active-low
- `inst_req` in 1: fetch request, held until `inst_addr_ok`
- `inst_wr` in 1: write flag; always 0 in practice, honoured if set
- `inst_size` in 2: 0=byte, 1=half, 2=word
- `inst_wstrb` in 4: write byte strobes
- `inst_addr` in ADDR_W: request address
- `inst_wdata` in DATA_W: write data
- `inst_addr_ok` out 1: request accepted
- `inst_data_ok` out 1: read data valid, or write done
- `inst_rdata` out DATA_W: read data
- `data_*` (same 10 ports as `inst_*`): load/store requester
- `bus_req` out 1: downstream request
- `bus_wr`, `bus_size`, `bus_wstrb`, `bus_addr`, `bus_wdata` out: latched request fields
- `bus_addr_ok` in 1: downstream accepted request
- `bus_data_ok` in 1: downstream response
- `bus_rdata` in DATA_W: downstream read data

## Operation
- FSM states:
  - IDLE
  - REQ: `bus_req`=1, fields driven from the capture register
  - WAIT: awaiting `bus_data_ok`
- IDLE with any requester pending:
  - Grant goes to data if `data_req`=1, unless `starve_cnt`==STARVE_LIMIT and `inst_req`=1; then fetch wins.
  - Winner's `*_addr_ok`=1 this cycle. Its fields and owner bit are captured. Next state is REQ.
- `starve_cnt`:
  - +1 on a data grant while `inst_req`=1, saturating at STARVE_LIMIT.
  - Cleared on any fetch grant.
  - Cleared on a data grant with `inst_req`=0.
- REQ: `bus_addr_ok`=1 moves to WAIT. Otherwise remain in REQ with fields stable.
- WAIT: `bus_data_ok`=1 pulses owner's `*_data_ok` in the same cycle, then returns to IDLE. The non-owner never sees data_ok.
- `bus_data_ok` in IDLE or REQ is a downstream protocol violation; it is ignored with no state change.
- `inst_rdata` and `data_rdata` are both wired to `bus_rdata`. They are meaningful only with their data_ok.
- Requesters may drop `*_req` before addr_ok. The arbiter samples `*_req` only in IDLE.
- Exactly one outstanding transaction at any time.

## Timing
- Reset (async, `resetn`=0): state=IDLE, owner=0, `starve_cnt`=0, capture register=0. All outputs 0 except `*_rdata`, which follow `bus_rdata`.
- Reset mid-transaction: the transaction is abandoned. The downstream bus shares the same reset.
- `*_addr_ok` and `*_data_ok` are combinational from state, owner and inputs. `bus_*` outputs are registered (from the capture register and state).
- Minimum latency:
  - cycle 0: addr_ok
  - cycle 1: `bus_req`, with `bus_addr_ok` accepted
  - cycle 2: earliest `bus_data_ok` → owner data_ok
- Back-to-back throughput: next grant no earlier than the cycle after data_ok, i.e. at best one transaction per 3 cycles.
- Simultaneous `inst_req` and `data_req` in IDLE: exactly one addr_ok asserts.

## Structure
- Shared package `cpu_mem_pkg`:
  - state encoding (IDLE/REQ/WAIT, 2-bit)
  - owner enum (OWN_INST=0, OWN_DATA=1)
  - request-bundle typedef {wr, size, wstrb, addr, wdata}
  - default STARVE_LIMIT
- Single module. No sub-module is warranted: the capture register and priority logic are small.

## Test plan
- Single fetch: `inst_req`, addr 0x1C000000; bus_addr_ok at cycle 1, bus_data_ok at cycle 2 with rdata 0x02800C0C → inst_addr_ok at cycle 0, inst_data_ok at cycle 2 with 0x02800C0C, `data_data_ok` stays 0.
- Conflict: both requests in the same cycle, data store to 0x100 with wstrb 0xF → data_addr_ok=1, inst_addr_ok=0. Bus shows wr=1, addr 0x100. Fetch is granted only after the store's data_ok.
- Starvation: `inst_req` held high, `data_req` reasserted continuously → 4 data grants, then a fetch grant. `starve_cnt` returns to 0.
- Stalls: bus_addr_ok withheld 5 cycles, then data_ok delayed 3 cycles → bus fields stable throughout REQ. Exactly one data_ok pulse.
- Async reset asserted in WAIT → all outputs drop to 0 immediately. After reset release, a new request is granted normally.
- Stray `bus_data_ok` in IDLE → no data_ok output, no state change.
